// File: rtl/corner_detect.sv
// corner_detect: FAST-style corner detector that scans a pixel stream, scores
// the longest circular arc of set bits in each 16-bit comparison vector,
// queues (x,y) of pixels whose arc reaches ARC_N in a show-ahead FIFO, and
// flags the frame end and any dropped corner.
// Optional build macro CORNER_SCORE_EN adds the corner_score output and its
// per-entry FIFO storage.
module corner_detect #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int ARC_N      = 9,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cmp_vec,
    input  logic        in_valid,
    output logic        corner_valid,
    input  logic        corner_ready,
    output logic [9:0]  corner_x,
    output logic [9:0]  corner_y,
    output logic        frame_done,
    output logic        overflow
`ifdef CORNER_SCORE_EN
    ,
    output logic [4:0]  corner_score
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Longest run of 1s around the circle; scanning the vector twice catches
    // runs that cross bit 15 -> bit 0, and the cap keeps all-ones at 16.
    function automatic logic [4:0] max_run(input logic [15:0] v);
        logic [31:0] d;
        logic [4:0]  c;
        logic [4:0]  m;
        d = {v, v};
        c = '0;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            c = d[i] ? ((c == 5'd16) ? c : c + 5'd1) : 5'd0;
            m = (c > m) ? c : m;
        end
        return m;
    endfunction

    logic [9:0]    r_x;
    logic [9:0]    r_y;
    logic          w_x_last;
    logic          w_y_last;
    logic [4:0]    w_run;
    logic          r_s1_valid;
    logic [4:0]    r_s1_run;
    logic [9:0]    r_s1_x;
    logic [9:0]    r_s1_y;
    logic          r_s2_valid;
    logic [4:0]    r_s2_run;
    logic [9:0]    r_s2_x;
    logic [9:0]    r_s2_y;
    logic [AW:0]   r_wr;
    logic [AW:0]   r_rd;
    logic [AW:0]   w_cnt;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;
    logic [9:0]    r_mem_x [FIFO_DEPTH];
    logic [9:0]    r_mem_y [FIFO_DEPTH];

    assign w_x_last = (r_x == 10'(IMG_W - 1));
    assign w_y_last = (r_y == 10'(IMG_H - 1));
    assign w_run    = max_run(cmp_vec);

    // Raster position of the next valid pixel; idle cycles hold it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (in_valid) begin
            r_x <= w_x_last ? '0 : r_x + 10'd1;
            r_y <= w_x_last ? (w_y_last ? '0 : r_y + 10'd1) : r_y;
        end
    end

    // End-of-frame pulse one edge after the last pixel is sampled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_done <= 1'b0;
        else       frame_done <= in_valid && w_x_last && w_y_last;
    end

    // Stage 1: capture arc length and pixel position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_run   <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_run   <= in_valid ? w_run : r_s1_run;
            r_s1_x     <= in_valid ? r_x : r_s1_x;
            r_s1_y     <= in_valid ? r_y : r_s1_y;
        end
    end

    // Stage 2: keep only pixels whose arc reaches the corner threshold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_run   <= '0;
            r_s2_x     <= '0;
            r_s2_y     <= '0;
        end else begin
            r_s2_valid <= r_s1_valid && (r_s1_run >= 5'(ARC_N));
            r_s2_run   <= r_s1_run;
            r_s2_x     <= r_s1_x;
            r_s2_y     <= r_s1_y;
        end
    end

    assign w_cnt   = r_wr - r_rd;
    assign w_empty = (r_wr == r_rd);
    assign w_full  = (w_cnt == (AW + 1)'(FIFO_DEPTH));
    assign w_pop   = !w_empty && corner_ready;
    assign w_wr_en = r_s2_valid && (!w_full || w_pop);

    // FIFO pointers and the sticky drop flag; a pop frees the slot a full push needs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr     <= '0;
            r_rd     <= '0;
            overflow <= 1'b0;
        end else begin
            r_wr     <= w_wr_en ? r_wr + 1'b1 : r_wr;
            r_rd     <= w_pop ? r_rd + 1'b1 : r_rd;
            overflow <= overflow || (r_s2_valid && w_full && !w_pop);
        end
    end

    // Entry storage; head outputs are masked while empty so no reset is needed here
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_x[r_wr[AW-1:0]] <= r_s2_x;
            r_mem_y[r_wr[AW-1:0]] <= r_s2_y;
        end
    end

    assign corner_valid = !w_empty;
    assign corner_x     = w_empty ? '0 : r_mem_x[r_rd[AW-1:0]];
    assign corner_y     = w_empty ? '0 : r_mem_y[r_rd[AW-1:0]];

`ifdef CORNER_SCORE_EN
    logic [4:0] r_mem_s [FIFO_DEPTH];

    // Per-entry arc length alongside the position
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem_s[r_wr[AW-1:0]] <= r_s2_run;
    end

    assign corner_score = w_empty ? '0 : r_mem_s[r_rd[AW-1:0]];
`else
    logic w_unused_run;
    assign w_unused_run = ^r_s2_run;
`endif

endmodule

// File: tb/tb_corner_detect.sv
// tb_corner_detect: randomized and directed checks of corner_detect against a
// queue-based reference model (IMG_W=4, IMG_H=2, ARC_N=9, FIFO_DEPTH=4).
module tb_corner_detect;
    localparam int W = 4;
    localparam int H = 2;
    localparam int ARC = 9;
    localparam int D = 4;

    typedef struct {
        int due;
        int x;
        int y;
        int s;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] cmp_vec = '0;
    logic        in_valid = 1'b0;
    logic        corner_valid;
    logic        corner_ready = 1'b0;
    logic [9:0]  corner_x;
    logic [9:0]  corner_y;
    logic        frame_done;
    logic        overflow;
    logic [4:0]  sc_now;

    int n_checks = 0;
    int n_fail = 0;

    ent_t mq[$];
    ent_t pend[$];
    ent_t got[$];
    int   cyc = 0;
    int   p = 0;
    bit   m_ovf = 0;
    bit   m_fd = 0;

`ifdef CORNER_SCORE_EN
    logic [4:0] corner_score;
    assign sc_now = corner_score;
`else
    assign sc_now = '0;
`endif

    corner_detect #(.IMG_W(W), .IMG_H(H), .ARC_N(ARC), .FIFO_DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .cmp_vec(cmp_vec),
        .in_valid(in_valid),
        .corner_valid(corner_valid),
        .corner_ready(corner_ready),
        .corner_x(corner_x),
        .corner_y(corner_y),
        .frame_done(frame_done),
        .overflow(overflow)
`ifdef CORNER_SCORE_EN
        ,
        .corner_score(corner_score)
`endif
    );

    always #5 clk = ~clk;

    function automatic int ref_run(input logic [15:0] v);
        int best;
        bit ok;
        best = 0;
        for (int s = 0; s < 16; s++)
            for (int l = 1; l <= 16; l++) begin
                ok = 1;
                for (int j = 0; j < l; j++) if (!v[(s + j) % 16]) ok = 0;
                if (ok && l > best) best = l;
            end
        return best;
    endfunction

    task automatic model_reset();
        mq.delete();
        pend.delete();
        got.delete();
        p = 0;
        m_ovf = 0;
        m_fd = 0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        corner_ready = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic v, input logic [15:0] vec, input logic rdy);
        ent_t e;
        int   pre;
        bit   popm;
        @(negedge clk);
        in_valid = v;
        cmp_vec = vec;
        corner_ready = rdy;
        if (corner_valid && rdy) begin
            e.due = 0; e.x = int'(corner_x); e.y = int'(corner_y); e.s = int'(sc_now);
            got.push_back(e);
        end
        @(posedge clk);
        cyc++;
        pre = mq.size();
        popm = (pre > 0) && rdy;
        if (popm) void'(mq.pop_front());
        if (pend.size() > 0 && pend[0].due == cyc) begin
            e = pend.pop_front();
            if (pre < D || popm) mq.push_back(e);
            else m_ovf = 1;
        end
        m_fd = v && (p % (W * H) == W * H - 1);
        if (v) begin
            if (ref_run(vec) >= ARC) begin
                e.due = cyc + 2; e.x = p % W; e.y = (p / W) % H; e.s = ref_run(vec);
                pend.push_back(e);
            end
            p++;
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({corner_valid, corner_x, corner_y, frame_done, overflow} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got cv=%0b x=%0d y=%0d fd=%0b ovf=%0b required all 0",
                     corner_valid, corner_x, corner_y, frame_done, overflow);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(0, 16'h0, 0);
        n_checks++;
        if (corner_valid !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got cv=%0b ovf=%0b required 0 0", corner_valid, overflow);
        end
    endtask

    task automatic test_basic();
        do_reset();
        step(1, 16'h01FF, 0);
        n_checks++;
        if (corner_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_edge_k got cv=%0b required 0", corner_valid);
        end
        step(0, 16'h0, 0);
        n_checks++;
        if (corner_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_edge_k1 got cv=%0b required 0", corner_valid);
        end
        step(0, 16'h0, 0);
        n_checks++;
        if (corner_valid !== 1'b1 || corner_x !== 10'd0 || corner_y !== 10'd0) begin
            n_fail++;
            $display("FAIL basic_edge_k2 got cv=%0b x=%0d y=%0d required 1 0 0", corner_valid, corner_x, corner_y);
        end
`ifdef CORNER_SCORE_EN
        n_checks++;
        if (corner_score !== 5'd9) begin
            n_fail++; $display("FAIL basic_score got %0d required 9", corner_score);
        end
`endif
        step(0, 16'h0, 1);
        n_checks++;
        if (corner_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_pop got cv=%0b required 0", corner_valid);
        end
    endtask

    task automatic test_wrap_arc();
        do_reset();
        step(1, 16'hC07F, 0);
        step(1, 16'h00FF, 0);
        step(0, 16'h0, 0);
        n_checks++;
        if (corner_valid !== 1'b1 || corner_x !== 10'd0) begin
            n_fail++; $display("FAIL wrap_arc_push got cv=%0b x=%0d required 1 0", corner_valid, corner_x);
        end
        step(0, 16'h0, 1);
        step(0, 16'h0, 0);
        n_checks++;
        if (corner_valid !== 1'b0) begin
            n_fail++; $display("FAIL short_arc_nopush got cv=%0b required 0", corner_valid);
        end
    endtask

    task automatic test_frame();
        int pulses;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 16'hFFFF, 1);
            if (frame_done) pulses++;
            if (i == 7) begin
                n_checks++;
                if (frame_done !== 1'b1) begin
                    n_fail++; $display("FAIL frame_done_last got %0b required 1", frame_done);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 16'h0, 1);
            if (frame_done) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL frame_done_pulses got %0d required 1", pulses);
        end
        n_checks++;
        if (got.size() != 8) begin
            n_fail++; $display("FAIL frame_count got %0d required 8", got.size());
        end
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_checks++;
            if (got[i].x != i % W || got[i].y != i / W) begin
                n_fail++;
                $display("FAIL frame_order[%0d] got (%0d,%0d) required (%0d,%0d)", i, got[i].x, got[i].y, i % W, i / W);
            end
`ifdef CORNER_SCORE_EN
            n_checks++;
            if (got[i].s != 16) begin
                n_fail++; $display("FAIL frame_score[%0d] got %0d required 16", i, got[i].s);
            end
`endif
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 16'hFFFF, 0);
        for (int i = 0; i < 3; i++) step(0, 16'h0, 0);
        n_checks++;
        if (overflow !== 1'b1 || corner_valid !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set got ovf=%0b cv=%0b required 1 1", overflow, corner_valid);
        end
        got.delete();
        for (int i = 0; i < 6; i++) step(0, 16'h0, 1);
        n_checks++;
        if (got.size() != 4) begin
            n_fail++; $display("FAIL ovf_kept got %0d entries required 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            n_checks++;
            if (got[i].x != i || got[i].y != 0) begin
                n_fail++; $display("FAIL ovf_entry[%0d] got (%0d,%0d) required (%0d,0)", i, got[i].x, got[i].y, i);
            end
        end
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky got %0b required 1", overflow);
        end
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 16'hFFFF, 0);
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        step(1, 16'hFFFF, 0);
        step(0, 16'h0, 0);
        got.delete();
        step(0, 16'h0, 1);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL full_push_pop_ovf got %0b required 0", overflow);
        end
        for (int i = 0; i < 5; i++) step(0, 16'h0, 1);
        n_checks++;
        if (got.size() != 5) begin
            n_fail++; $display("FAIL full_push_pop_count got %0d required 5", got.size());
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_checks++;
            if (got[i].x != i % W || got[i].y != i / W) begin
                n_fail++;
                $display("FAIL full_push_pop_entry[%0d] got (%0d,%0d) required (%0d,%0d)", i, got[i].x, got[i].y, i % W, i / W);
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 16'hFFFF, 0);
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        step(1, 16'hFFFF, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (corner_valid !== 1'b0 || corner_x !== 10'd0 || corner_y !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_now got cv=%0b x=%0d y=%0d required 0 0 0", corner_valid, corner_x, corner_y);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 16'h0, 0);
            n_checks++;
            if (corner_valid !== 1'b0) begin
                n_fail++; $display("FAIL midreset_inflight[%0d] got cv=%0b required 0", i, corner_valid);
            end
        end
        step(1, 16'hFFFF, 0);
        step(0, 16'h0, 0);
        step(0, 16'h0, 0);
        n_checks++;
        if (corner_valid !== 1'b1 || corner_x !== 10'd0 || corner_y !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_tag got cv=%0b x=%0d y=%0d required 1 0 0", corner_valid, corner_x, corner_y);
        end
    endtask

    task automatic test_no_corner();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1, (i % 2 == 0) ? 16'h0000 : 16'hAAAA, 0);
            n_checks++;
            if (corner_valid !== 1'b0) begin
                n_fail++; $display("FAIL no_corner[%0d] got cv=%0b required 0", i, corner_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] vec;
        logic [31:0] t;
        int          k;
        int          l;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 3);
            l = $urandom_range(6, 15);
            t = (32'd1 << l) - 32'd1;
            t = {t[15:0], t[15:0]} >> $urandom_range(0, 15);
            vec = (k == 0) ? 16'($urandom) : (k == 1) ? 16'hFFFF : t[15:0];
            step($urandom_range(0, 3) != 0, vec, $urandom_range(0, 2) == 0);
            n_checks++;
            if (corner_valid !== (mq.size() > 0) || overflow !== m_ovf || frame_done !== m_fd) begin
                n_fail++;
                $display("FAIL rand_flags[%0d] got cv=%0b ovf=%0b fd=%0b required %0b %0b %0b",
                         i, corner_valid, overflow, frame_done, mq.size() > 0, m_ovf, m_fd);
            end
            if (mq.size() > 0) begin
                n_checks++;
                if (int'(corner_x) != mq[0].x || int'(corner_y) != mq[0].y) begin
                    n_fail++;
                    $display("FAIL rand_head[%0d] got (%0d,%0d) required (%0d,%0d)", i, corner_x, corner_y, mq[0].x, mq[0].y);
                end
`ifdef CORNER_SCORE_EN
                n_checks++;
                if (int'(corner_score) != mq[0].s) begin
                    n_fail++; $display("FAIL rand_score[%0d] got %0d required %0d", i, corner_score, mq[0].s);
                end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_arc();
        test_frame();
        test_overflow();
        test_reset_midflight();
        test_no_corner();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
